// File: rtl/fetch_stage_pkg.sv
// Shared constants, FSM state type and PC helper for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam logic [15:0] RESET_PC_DEFAULT  = 16'h0000;
  localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0800;
  localparam logic [15:0] PC_STEP_DEFAULT   = 16'd2;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } fetch_state_e;

  // 16-bit modulo increment; wraps 16'hFFFE -> 16'h0000 silently.
  function automatic logic [15:0] pc_inc(input logic [15:0] pc, input logic [15:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory req/ack bus between the fetch stage (master) and memory (slave).
interface fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: holds while stalled, loads a real instruction, otherwise becomes a bubble.
module fetch_ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        load,
  input  logic [15:0] instr_in,
  input  logic [15:0] next_pc_in,
  output logic [15:0] instruct,
  output logic [15:0] next_pc,
  output logic        instr_valid
);

  logic [15:0] instruct_d, instruct_q;
  logic [15:0] next_pc_d,  next_pc_q;
  logic        valid_d,    valid_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    instruct_d = instruct_q;
    next_pc_d  = next_pc_q;
    valid_d    = valid_q;
    if (!hold) begin
      if (load) begin
        instruct_d = instr_in;
        next_pc_d  = next_pc_in;
        valid_d    = 1'b1;
      end else begin
        // Bubble keeps NextPC; decode ignores it when InstrValid is low.
        instruct_d = NOP_INSTR;
        valid_d    = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      instruct_q <= NOP_INSTR;
      next_pc_q  <= RESET_PC;
      valid_q    <= 1'b0;
    end else begin
      instruct_q <= instruct_d;
      next_pc_q  <= next_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign instruct    = instruct_q;
  assign next_pc     = next_pc_q;
  assign instr_valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC ownership, req/ack fetch FSM with skid and squash, IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating stall-cycle and squashed-word counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEFAULT,
  parameter logic [15:0] PC_STEP   = PC_STEP_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Stall,
  input  logic                Redirect,
  input  logic [15:0]         RedirectPC,
  fetch_stage_if.master       imem,
  output logic [15:0]         Instruct,
  output logic [15:0]         NextPC,
  output logic                InstrValid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]         PerfStallCyc,
  output logic [15:0]         PerfSquash
`endif
);

  fetch_state_e state_d, state_q;
  logic [15:0]  pc_d, pc_q;
  logic [15:0]  target_d, target_q;
  logic [15:0]  skid_instr_d, skid_instr_q;
  logic [15:0]  skid_pc_d, skid_pc_q;

  logic        req, ack_ok, redir_ok, squash_evt;
  logic        ifid_load;
  logic [15:0] ifid_instr, ifid_next_pc;

  assign req       = (state_q != HOLD) && !rst;
  assign ack_ok    = imem.imem_ack && req;
  assign redir_ok  = Redirect && !Stall;
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    target_d     = target_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    ifid_load    = 1'b0;
    ifid_instr   = imem.imem_rdata;
    ifid_next_pc = pc_inc(pc_q, PC_STEP);
    squash_evt   = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (ack_ok) begin
          if (redir_ok) begin
            pc_d       = RedirectPC;
            squash_evt = 1'b1;
          end else if (Stall) begin
            skid_instr_d = imem.imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = HOLD;
          end else begin
            ifid_load = 1'b1;
            pc_d      = pc_inc(pc_q, PC_STEP);
          end
        end else if (redir_ok) begin
          // Address must stay put until the outstanding request is acked.
          target_d = RedirectPC;
          state_d  = SQUASH;
        end
      end
      HOLD: begin
        if (!Stall) begin
          state_d = FETCH;
          if (Redirect) begin
            pc_d       = RedirectPC;
            squash_evt = 1'b1;
          end else begin
            ifid_load    = 1'b1;
            ifid_instr   = skid_instr_q;
            ifid_next_pc = pc_inc(skid_pc_q, PC_STEP);
            pc_d         = pc_inc(skid_pc_q, PC_STEP);
          end
        end
      end
      SQUASH: begin
        if (redir_ok) target_d = RedirectPC;
        if (ack_ok) begin
          pc_d       = redir_ok ? RedirectPC : target_q;
          squash_evt = 1'b1;
          state_d    = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // NOTE: skid/target data regs are reset too, so no X ever reaches IF/ID after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      target_q     <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      target_q     <= target_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  fetch_ifid_reg #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk         (clk),
    .rst         (rst),
    .hold        (Stall),
    .load        (ifid_load),
    .instr_in    (ifid_instr),
    .next_pc_in  (ifid_next_pc),
    .instruct    (Instruct),
    .next_pc     (NextPC),
    .instr_valid (InstrValid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_d, stall_cnt_q;
  logic [15:0] squash_cnt_d, squash_cnt_q;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (req && !imem.imem_ack && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    if (squash_evt && squash_cnt_q != 16'hFFFF)           squash_cnt_d = squash_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= 16'h0000;
      squash_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign PerfStallCyc = stall_cnt_q;
  assign PerfSquash   = squash_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; bench-driven memory responder, values hand-computed.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        Stall;
  logic        Redirect;
  logic [15:0] RedirectPC;
  logic [15:0] Instruct;
  logic [15:0] NextPC;
  logic        InstrValid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] PerfStallCyc;
  logic [15:0] PerfSquash;
`endif

  fetch_stage_if imem_bus ();

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .imem       (imem_bus),
    .Instruct   (Instruct),
    .NextPC     (NextPC),
    .InstrValid (InstrValid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .PerfStallCyc (PerfStallCyc),
    .PerfSquash   (PerfSquash)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One cycle with memory acking (if a request is up) with the given word.
  task automatic mem_ack(input logic [15:0] word);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = word;
    tick();
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 16'h0000;
  endtask

  initial begin
    rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 16'h0000;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 16'h0000;
    @(negedge clk);
    tick();

    // Reset state
    check("rst_req",    {15'd0, imem_bus.imem_req}, 16'h0000);
    check("rst_instr",  Instruct,                   16'h0800);
    check("rst_nextpc", NextPC,                     16'h0000);
    check("rst_valid",  {15'd0, InstrValid},        16'h0000);
    rst = 1'b0;
    #1;
    check("s1_req0",  {15'd0, imem_bus.imem_req}, 16'h0001);
    check("s1_addr0", imem_bus.imem_addr,         16'h0000);

    // 1: zero-wait stream
    mem_ack(16'hA000);
    check("s1_instrA", Instruct,           16'hA000);
    check("s1_npcA",   NextPC,             16'h0002);
    check("s1_validA", {15'd0, InstrValid}, 16'h0001);
    check("s1_addr2",  imem_bus.imem_addr, 16'h0002);
    mem_ack(16'hA002);
    check("s1_instrB", Instruct,           16'hA002);
    check("s1_npcB",   NextPC,             16'h0004);
    check("s1_addr4",  imem_bus.imem_addr, 16'h0004);

    // 2: ack while stalled goes to skid, IF/ID frozen, released next cycle
    Stall = 1'b1;
    mem_ack(16'hA004);
    check("s2_req_drop",  {15'd0, imem_bus.imem_req}, 16'h0000);
    check("s2_frz_instr", Instruct,                   16'hA002);
    tick(); tick();
    check("s2_frz_instr3", Instruct,           16'hA002);
    check("s2_frz_npc3",   NextPC,             16'h0004);
    check("s2_frz_valid3", {15'd0, InstrValid}, 16'h0001);
    check("s2_req_low3",   {15'd0, imem_bus.imem_req}, 16'h0000);
    Stall = 1'b0;
    tick();
    check("s2_instrC", Instruct,           16'hA004);
    check("s2_npcC",   NextPC,             16'h0006);
    check("s2_addr6",  imem_bus.imem_addr, 16'h0006);
    check("s2_req_up", {15'd0, imem_bus.imem_req}, 16'h0001);

    // 3: redirect while ack pending -> address held, returned word dropped
    Redirect = 1'b1; RedirectPC = 16'h0100;
    tick();
    check("s3_addr_hold1", imem_bus.imem_addr, 16'h0006);
    check("s3_bubble_v",   {15'd0, InstrValid}, 16'h0000);
    check("s3_bubble_i",   Instruct,           16'h0800);
    tick(); tick();
    check("s3_addr_hold3", imem_bus.imem_addr, 16'h0006);
    check("s3_req_held",   {15'd0, imem_bus.imem_req}, 16'h0001);
    Redirect = 1'b0;
    mem_ack(16'hA006);
    check("s3_addr_tgt", imem_bus.imem_addr,  16'h0100);
    check("s3_dropped",  {15'd0, InstrValid}, 16'h0000);
    check("s3_drop_i",   Instruct,            16'h0800);
`ifdef FETCH_PERF_CNT_EN
    check("s3_perf_squash", PerfSquash,   16'h0001);
    check("s3_perf_stall",  PerfStallCyc, 16'h0003);
`endif

    // 4: redirect under Stall ignored, then taken
    Stall = 1'b1; Redirect = 1'b1; RedirectPC = 16'h0200;
    tick();
    check("s4_ign_addr", imem_bus.imem_addr, 16'h0100);
    check("s4_frz_npc",  NextPC,             16'h0006);
    Stall = 1'b0;
    tick();
    Redirect = 1'b0;
    check("s4_sq_addr", imem_bus.imem_addr, 16'h0100);
    mem_ack(16'hA100);
    check("s4_taken", imem_bus.imem_addr, 16'h0200);

    // 5: ack+redirect same cycle to 0xFFFE, then wrap on fetch
    Redirect = 1'b1; RedirectPC = 16'hFFFE;
    mem_ack(16'hA200);
    Redirect = 1'b0;
    check("s5_addr_fffe", imem_bus.imem_addr,  16'hFFFE);
    check("s5_bubble",    {15'd0, InstrValid}, 16'h0000);
    mem_ack(16'hB000);
    check("s5_instr", Instruct,           16'hB000);
    check("s5_npc",   NextPC,             16'h0000);
    check("s5_addr0", imem_bus.imem_addr, 16'h0000);

    // Redirect out of HOLD discards skid
    Stall = 1'b1;
    mem_ack(16'hB002);
    check("h_frz_instr", Instruct, 16'hB000);
    Stall = 1'b0; Redirect = 1'b1; RedirectPC = 16'h0040;
    tick();
    Redirect = 1'b0;
    check("h_addr",  imem_bus.imem_addr,  16'h0040);
    check("h_valid", {15'd0, InstrValid}, 16'h0000);
    check("h_req",   {15'd0, imem_bus.imem_req}, 16'h0001);

    // 6: reset mid-request, late ack ignored
    rst = 1'b1;
    tick();
    check("s6_req_rst", {15'd0, imem_bus.imem_req}, 16'h0000);
    mem_ack(16'hDEAD);
    check("s6_instr", Instruct,           16'h0800);
    check("s6_valid", {15'd0, InstrValid}, 16'h0000);
    check("s6_npc",   NextPC,             16'h0000);
    rst = 1'b0;
    #1;
    check("s6_req",  {15'd0, imem_bus.imem_req}, 16'h0001);
    check("s6_addr", imem_bus.imem_addr,         16'h0000);
`ifdef FETCH_PERF_CNT_EN
    check("s6_perf_stall0",  PerfStallCyc, 16'h0000);
    check("s6_perf_squash0", PerfSquash,   16'h0000);
`endif
    mem_ack(16'hC000);
    check("s6_first_instr", Instruct,           16'hC000);
    check("s6_first_npc",   NextPC,             16'h0002);
    check("s6_next_addr",   imem_bus.imem_addr, 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
